// File: rtl/mov_wide_encoder.sv
// Emits the shortest LEGv8 MOVZ/MOVK sequence that materializes a 64-bit constant.
// Inst/Last are registered and precomputed for the next beat, so no input reaches an output combinationally.
module mov_wide_encoder (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] Imm,
  input  logic [4:0]  Rd,
  input  logic        InValid,
  output logic        InReady,
  output logic [31:0] Inst,
  output logic        InstValid,
  input  logic        InstReady,
  output logic        Last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [8:0] OPC_MOVZ = 9'b110100101;
  localparam logic [8:0] OPC_MOVK = 9'b111100101;

  logic [0:0]  state;
  logic [63:0] imm_q;
  logic [4:0]  rd_q;
  logic [3:0]  pending;

  logic [3:0]  in_mask;
  logic [3:0]  pend_nx;

  function automatic logic [1:0] low_idx(input logic [3:0] pend);
    logic [1:0] h;
    h = 2'd0;
    if (pend[0])      h = 2'd0;
    else if (pend[1]) h = 2'd1;
    else if (pend[2]) h = 2'd2;
    else if (pend[3]) h = 2'd3;
    return h;
  endfunction

  function automatic logic at_most_one(input logic [3:0] pend);
    return (pend & (pend - 4'd1)) == 4'd0;
  endfunction

  function automatic logic [31:0] encode(input logic [63:0] imm, input logic [4:0] rd,
                                         input logic [3:0] pend, input logic first);
    logic [1:0]  h;
    logic [15:0] hw;
    h = low_idx(pend);
    case (h)
      2'd0:    hw = imm[15:0];
      2'd1:    hw = imm[31:16];
      2'd2:    hw = imm[47:32];
      default: hw = imm[63:48];
    endcase
    return {(first ? OPC_MOVZ : OPC_MOVK), h, hw, rd};
  endfunction

  always_comb begin
    in_mask = '0;
    for (int unsigned k = 0; k < 4; k++)
      in_mask[k] = (Imm[16*k +: 16] != 16'h0000);
    pend_nx = pending & ~(4'b0001 << low_idx(pending));
  end

  // The MOVZ/MOVK choice is made when the beat is loaded: the accept path always
  // builds the first beat, the transfer path always builds a follow-on beat.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      imm_q     <= '0;
      rd_q      <= '0;
      pending   <= '0;
      Inst      <= '0;
      InstValid <= 1'b0;
      Last      <= 1'b0;
      InReady   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            imm_q     <= Imm;
            rd_q      <= Rd;
            pending   <= in_mask;
            Inst      <= encode(Imm, Rd, in_mask, 1'b1);
            Last      <= at_most_one(in_mask);
            InstValid <= 1'b1;
            InReady   <= 1'b0;
            state     <= EMIT;
          end
        end
        default: begin
          if (InstReady) begin
            pending <= pend_nx;
            if (Last) begin
              InstValid <= 1'b0;
              Last      <= 1'b0;
              InReady   <= 1'b1;
              state     <= IDLE;
            end else begin
              Inst <= encode(imm_q, rd_q, pend_nx, 1'b0);
              Last <= at_most_one(pend_nx);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mov_wide_encoder.sv
// Directed bench for mov_wide_encoder with hand-computed MOVZ/MOVK words.
module tb_mov_wide_encoder;

  logic        CLK;
  logic        Reset_L;
  logic [63:0] Imm;
  logic [4:0]  Rd;
  logic        InValid;
  logic        InReady;
  logic [31:0] Inst;
  logic        InstValid;
  logic        InstReady;
  logic        Last;

  int unsigned n_cmp;
  int unsigned n_err;

  mov_wide_encoder dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .Imm       (Imm),
    .Rd        (Rd),
    .InValid   (InValid),
    .InReady   (InReady),
    .Inst      (Inst),
    .InstValid (InstValid),
    .InstReady (InstReady),
    .Last      (Last)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents one constant, scrambles Imm/Rd after acceptance, and checks n beats at full rate.
  task automatic run_seq(input string tag, input logic [63:0] imm, input logic [4:0] rd,
                         input logic [31:0] beats [4], input int n);
    Imm = imm; Rd = rd; InValid = 1'b1; InstReady = 1'b1;
    step();
    InValid = 1'b0; Imm = ~imm; Rd = ~rd;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 64'(InstValid), 64'(1));
      check({tag, "_inst"},  64'(Inst), 64'(beats[i]));
      check({tag, "_last"},  64'(Last), 64'(i == n - 1));
      check({tag, "_inready_low"}, 64'(InReady), 64'(0));
      step();
    end
    check({tag, "_done_valid"}, 64'(InstValid), 64'(0));
    check({tag, "_done_inready"}, 64'(InReady), 64'(1));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    Reset_L = 1'b0; Imm = '0; Rd = '0; InValid = 1'b0; InstReady = 1'b1;
    #12 Reset_L = 1'b1;
    step();

    check("rst_inready", 64'(InReady), 64'(1));
    check("rst_instvalid", 64'(InstValid), 64'(0));
    check("rst_inst", 64'(Inst), 64'(0));
    check("rst_last", 64'(Last), 64'(0));

    run_seq("zero", 64'h0, 5'd0, '{32'hD2800000, 32'h0, 32'h0, 32'h0}, 1);
    run_seq("lowhw", 64'h1234, 5'd3, '{32'hD2824683, 32'h0, 32'h0, 32'h0}, 1);
    run_seq("highhw", 64'h0000_5678_0000_0000, 5'd1, '{32'hD2CACF01, 32'h0, 32'h0, 32'h0}, 1);

    // Sparse halfwords with 3 stalled cycles on the first beat
    Imm = 64'h0001_0000_0000_0002; Rd = 5'd2; InValid = 1'b1;
    step();
    InValid = 1'b0; InstReady = 1'b0; Imm = '1;
    check("sparse_b0_inst", 64'(Inst), 64'hD2800042);
    check("sparse_b0_last", 64'(Last), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("sparse_stall_valid", 64'(InstValid), 64'(1));
      check("sparse_stall_inst", 64'(Inst), 64'hD2800042);
      check("sparse_stall_last", 64'(Last), 64'(0));
    end
    InstReady = 1'b1;
    step();
    check("sparse_b1_inst", 64'(Inst), 64'hF2E00022);
    check("sparse_b1_last", 64'(Last), 64'(1));
    check("sparse_b1_valid", 64'(InstValid), 64'(1));
    step();
    check("sparse_done_valid", 64'(InstValid), 64'(0));
    check("sparse_done_inready", 64'(InReady), 64'(1));

    // All ones, full rate, then back-to-back acceptance in the bubble cycle
    run_seq("ones", 64'hFFFF_FFFF_FFFF_FFFF, 5'd31,
            '{32'hD29FFFFF, 32'hF2BFFFFF, 32'hF2DFFFFF, 32'hF2FFFFFF}, 4);
    run_seq("b2b", 64'h1234, 5'd3, '{32'hD2824683, 32'h0, 32'h0, 32'h0}, 1);

    // Reset after the second beat has transferred
    Imm = 64'hFFFF_FFFF_FFFF_FFFF; Rd = 5'd31; InValid = 1'b1; InstReady = 1'b1;
    step();
    InValid = 1'b0;
    check("abort_b0_inst", 64'(Inst), 64'hD29FFFFF);
    step();
    check("abort_b1_inst", 64'(Inst), 64'hF2BFFFFF);
    step();
    check("abort_b2_inst", 64'(Inst), 64'hF2DFFFFF);
    Reset_L = 1'b0;
    #1;
    check("abort_valid", 64'(InstValid), 64'(0));
    check("abort_inst", 64'(Inst), 64'(0));
    check("abort_last", 64'(Last), 64'(0));
    step();
    Reset_L = 1'b1;
    step();
    check("abort_inready", 64'(InReady), 64'(1));
    check("abort_idle_valid", 64'(InstValid), 64'(0));
    run_seq("post_abort", 64'h1234, 5'd3, '{32'hD2824683, 32'h0, 32'h0, 32'h0}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mov_wide_encoder.md
# mov_wide_encoder

Sequential immediate-to-instruction encoder: accepts a 64-bit constant and a destination register and emits the shortest LEGv8 MOVZ/MOVK sequence that materializes that constant. Each emitted instruction places its 16-bit payload in Inst[20:5] and its shift selector in Inst[22:21], the exact fields the datapath's wide-move immediate extension consumes. The block sits between a constant source (test/program generator or loader) and the instruction memory write port. Both sides use valid/ready handshakes.

## Interface
- No parameters. Widths fixed by the LEGv8 format.
- CLK  in  1  clock, rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- Imm  in  64  constant to materialize.
- Rd  in  5  destination register number.
- InValid  in  1  Imm/Rd valid.
- InReady  out  1  block can accept a new constant.
- Inst  out  32  encoded instruction.
- InstValid  out  1  Inst valid.
- InstReady  in  1  downstream accepts Inst.
- Last  out  1  current Inst is the final one of the sequence.

## Operation
- **States**
  - IDLE: InReady=1, InstValid=0.
  - EMIT: InReady=0, InstValid=1.
- **Accept.** On InValid&&InReady in IDLE:
  - Latch Imm and Rd.
  - Form Pending[3:0] = halfword-nonzero mask (bit k set iff Imm[16k+15:16k]!=0).
  - Set First=1 and go to EMIT.
- **Current halfword index H.** H is the lowest set bit of Pending. If Pending==0 (Imm==0), H=0.
- **Encoding of Inst**
  - Inst[31:23] = 9'b110100101 (MOVZ) when First=1; 9'b111100101 (MOVK) otherwise.
  - Inst[22:21] = H.
  - Inst[20:5] = latched Imm[16H+15:16H].
  - Inst[4:0] = latched Rd.
- **Last** = 1 when Pending has at most one set bit.
- **Transfer.** On InstValid&&InstReady in EMIT:
  - Clear bit H of Pending and set First=0.
  - If Last, return to IDLE.
- **Ordering.**
  - Halfwords are emitted in ascending H order.
  - Zero halfwords are skipped. The MOVZ already zeroes them.
  - Sequence length is max(1, popcount(Pending)), range 1..4.
- **Stall.** While InstReady=0, Inst, Last and all state hold unchanged.
- **Isolation.** Imm/Rd changes after acceptance have no effect. The latched copy is used.
- **Reset.** Reset_L low at any time, including mid-sequence:
  - State returns to IDLE immediately; the partial sequence is abandoned with no further output.
  - Inst=0, InstValid=0, Last=0, InReady=1.
  - Pending=0, First=0.
  - Latched Imm/Rd are cleared to 0.

## Timing
- All outputs are driven from registers only. There is no combinational path from Imm/Rd/InValid/InstReady to any output.
- Acceptance at edge N: the first Inst is valid in cycle N+1 (latency 1).
- With InstReady held high, one instruction transfers per cycle.
- The final transfer at edge M returns the block to IDLE, so InReady=1 in cycle M+1. The earliest next acceptance is edge M+1, giving one bubble between sequences.
- InstValid stays asserted until the transfer occurs. It never deasserts without a handshake.
- InReady=0 throughout EMIT. InValid during EMIT is ignored and must be held by the source.

## Test plan
- **Zero constant.** Reset, then Imm=0, Rd=0.
  - One beat: Inst=0xD2800000, Last=1.
  - InReady returns high the next cycle.
- **Single low halfword.** Imm=0x1234, Rd=3.
  - One beat: Inst=0xD2824683, Last=1.
- **Single high halfword.** Imm=0x0000_5678_0000_0000, Rd=1.
  - One beat: Inst=0xD2CACF01 (MOVZ, hw=2), Last=1.
- **Sparse halfwords with backpressure.** Imm=0x0001_0000_0000_0002, Rd=2, InstReady low for 3 cycles.
  - Inst=0xD2800042 holds stable through the stall.
  - Then Inst=0xF2E00022 with Last=1. Exactly 2 beats.
- **All ones, full rate.** Imm=0xFFFF_FFFF_FFFF_FFFF, Rd=31, InstReady=1.
  - Beats 0xD29FFFFF, 0xF2BFFFFF, 0xF2DFFFFF, 0xF2FFFFFF on consecutive cycles.
  - Last only on the fourth beat.
  - A second constant presented with InValid is accepted one cycle after the final beat.
- **Reset mid-sequence.** Same all-ones input; assert Reset_L low after the second beat.
  - InstValid=0, Inst=0, Last=0 immediately.
  - InReady=1 after release.
  - A new Imm=0x1234, Rd=3 yields 0xD2824683 with no residue from the aborted sequence.
